mmio_gpio: RTL and testbench
============================

Name: mmio_gpio

Overview:
- Memory-mapped GPIO peripheral for the single-cycle RISC-V SoC; replaces the hard-wired switch/key-to-LED glue in the top level.
- Sits beside dmem on the core's data bus (same enable/address/write-data/read-data signals) and responds only inside its own address window.
- Adds over the old glue: parametrised I/O widths, switch synchronisers, per-key debounce, sticky key-press capture, and a software-driven LED register.
- A legacy mode keeps the old LED behaviour: LEDs show the switches while no key is pressed.

Parameters:
- NUM_SW, 10: switch inputs (1..32).
- NUM_KEY, 3: push-buttons, active-low at the pin (1..32).
- NUM_LED, 10: LED outputs (1..32).
- BASE_ADDR, 32'h0000_0100: byte base of a 32-byte window; must be 32-byte aligned.
- DEBOUNCE_CYCLES, 50000: cycles a synchronised key level must hold before it is accepted (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enabler_write  input  1  store strobe from the core.
- address  input  32  byte address from the core.
- data_write  input  32  store data.
- data_read  output  32  load data; zero when the address is outside the window.
- hit  output  1  address is inside the window; the top level uses it to mux data_read against dmem and to gate dmem writes.
- sw  input  NUM_SW  raw switch pins, asynchronous.
- key  input  NUM_KEY  raw key pins, active-low, asynchronous.
- led  output  NUM_LED  LED drive.

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high. Every flop clears immediately when reset goes high.
- Address decode:
  - hit = (address[31:5] == BASE_ADDR[31:5]).
  - off = address[4:2]. address[1:0] is ignored; only word access is supported.
- Reads are combinational with zero latency, matching dmem. Unused upper bits read as 0.
- Writes take effect at the rising edge when enabler_write && hit. Writes to read-only or unmapped offsets are ignored.
- Register map (offset in hex, access, reset value):
  - 0x00 CTRL, RW, 0: bit0 MODE. 0 = legacy mirror, 1 = LED register drives led.
  - 0x04 LED_OUT, RW, 0: bits [NUM_LED-1:0].
  - 0x08 SW_IN, RO: synchronised switch levels.
  - 0x0C KEY_IN, RO: debounced pressed flags (1 = pressed).
  - 0x10 KEY_EDGE, RW1C, 0: bit set on each debounced released->pressed transition.
  - 0x14 PRESS_CNT, RO, 0: 16-bit total accepted presses. Wraps at 0xFFFF->0.
  - 0x18, 0x1C: read 0.
- Synchronisers:
  - Two-flop sync per sw and key bit.
  - Reset values: sw flops 0; key flops 1 (released).
- Debounce (per key; state is stable flag + counter sized for DEBOUNCE_CYCLES):
  - If sample == stable: counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, stable toggles on the next edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES changes nothing.
  - Latency from pin change to KEY_IN update is DEBOUNCE_CYCLES+2 cycles.
- Edge capture:
  - A debounced 0->1 on pressed[i] sets KEY_EDGE[i] and increments PRESS_CNT by 1 per key that rises in that cycle (up to NUM_KEY in one cycle).
  - If a W1C write and a set hit the same bit in the same cycle, set wins.
  - Release transitions set nothing.
- LED drive (combinational from registers):
  - MODE=1: led = LED_OUT.
  - MODE=0: led[i] = SW_IN[i] & ~|KEY_IN for i<NUM_SW; led[i] = 0 for i>=NUM_SW.
  - After reset, led = 0.
- Reset mid-operation: pending debounce counts, captured edges and the press count are all discarded.

Decomposition:
- Package gpio_pkg holds:
  - offset constants OFF_CTRL, OFF_LED, OFF_SW, OFF_KEY, OFF_EDGE, OFF_CNT;
  - the CTRL bit index;
  - the window size localparam (32).
- Sub-module key_debounce (one instance per key, generated) holds:
  - the 2-flop sync, counter and stable flag;
  - a one-cycle rise pulse output.
- Switch syncs, register file, decode and LED mux stay in mmio_gpio.

Test Plan (DEBOUNCE_CYCLES=4, defaults otherwise):
- Reset values: assert reset with sw=10'h3FF and key=3'b111, then release. led=0 during reset. led=10'h3FF two cycles after release. Reading 0x00/0x04/0x10/0x14 returns 0.
- Legacy mask: sw=10'h155; drive key[1]=0 for 10 cycles. led goes 10'h155 -> 0 at cycle DEBOUNCE_CYCLES+2. KEY_IN=3'b010. KEY_EDGE=3'b010. PRESS_CNT=1.
- Glitch rejection: key[0] low for 3 cycles, then high. KEY_IN stays 0. KEY_EDGE stays 0. PRESS_CNT unchanged.
- Register mode and decode: write 0x104<-0x2A5, then 0x100<-1. led=10'h2A5. A write to 0x120 (outside window) leaves the state unchanged and hit=0. A read of 0x120 gives data_read=0.
- W1C with set collision: KEY_EDGE=3'b011. Write 0x110<-3'b001 in the same cycle key[0] produces a new debounced press. Result: KEY_EDGE=3'b011. A later write 0x110<-3'b011 gives 0.
- Counter wrap: preload via 0xFFFF presses (or force the counter), then one more press. PRESS_CNT reads 0.

Source files
------------

// File: rtl/mmio_gpio_pkg.sv
// Shared constants for the memory-mapped GPIO peripheral.
// Holds the register offsets (word index within the window), the CTRL bit
// layout, the address window size and the press counter width.
package gpio_pkg;

  localparam int unsigned WINDOW_BYTES = 32;
  localparam int unsigned WINDOW_LSB   = $clog2(WINDOW_BYTES);

  // Word offsets, i.e. address[4:2].
  localparam logic [2:0] OFF_CTRL = 3'd0;
  localparam logic [2:0] OFF_LED  = 3'd1;
  localparam logic [2:0] OFF_SW   = 3'd2;
  localparam logic [2:0] OFF_KEY  = 3'd3;
  localparam logic [2:0] OFF_EDGE = 3'd4;
  localparam logic [2:0] OFF_CNT  = 3'd5;

  localparam int unsigned CTRL_MODE_BIT = 0;
  localparam int unsigned PRESS_CNT_W   = 16;

endpackage

// File: rtl/mmio_gpio_if.sv
// Core data-bus slice shared by dmem and the GPIO peripheral.
//   enabler_write : store strobe
//   address       : byte address
//   data_write    : store data
//   data_read     : load data (zero outside the peripheral window)
//   hit           : address falls inside the peripheral window
interface mmio_gpio_if;
  logic        enabler_write;
  logic [31:0] address;
  logic [31:0] data_write;
  logic [31:0] data_read;
  logic        hit;

  modport master (
    output enabler_write, address, data_write,
    input  data_read, hit
  );

  modport slave (
    input  enabler_write, address, data_write,
    output data_read, hit
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key synchroniser and debouncer.
//   clk, reset : system clock, async active-high reset
//   key_n      : raw active-low key pin (asynchronous)
//   pressed    : debounced level, 1 = pressed
//   rise       : one-cycle pulse in the cycle whose closing edge accepts a press
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q;  // accepted pin level, 1 = released
  logic [CNT_W-1:0] cnt_q;
  logic             flip;

  assign flip = (sync2_q != stable_q) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (flip) begin
        stable_q <= ~stable_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign pressed = ~stable_q;
  // Accepting a change while the pin was released means a new press.
  assign rise    = flip & stable_q;

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO peripheral on the core data bus.
//   clk, reset : system clock, async active-high reset
//   bus        : data-bus slave (store strobe, address, data, load data, hit)
//   sw         : raw switch pins
//   key        : raw active-low key pins
//   led        : LED drive; mirrors switches masked by any key in legacy mode,
//                otherwise the software LED register
module mmio_gpio
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_SW          = 10,
  parameter int unsigned NUM_KEY         = 3,
  parameter int unsigned NUM_LED         = 10,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0100,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  mmio_gpio_if.slave         bus,
  input  logic [NUM_SW-1:0]  sw,
  input  logic [NUM_KEY-1:0] key,
  output logic [NUM_LED-1:0] led
);

  logic [2:0]             off;
  logic                   we;
  logic [NUM_SW-1:0]      sw_s1_q, sw_s2_q;
  logic [NUM_KEY-1:0]     pressed, rise;
  logic                   mode_q;
  logic [NUM_LED-1:0]     led_q;
  logic [NUM_KEY-1:0]     edge_q, edge_d;
  logic [PRESS_CNT_W-1:0] press_cnt_q, press_inc;
  logic [31:0]            rdata;
  logic [31:0]            sw_pad;

  assign bus.hit = (bus.address[31:WINDOW_LSB] == BASE_ADDR[31:WINDOW_LSB]);
  assign off     = bus.address[4:2];
  assign we      = bus.enabler_write & bus.hit;

  for (genvar i = 0; i < NUM_KEY; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .key_n  (key[i]),
      .pressed(pressed[i]),
      .rise   (rise[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= 1'b0;
      led_q  <= '0;
    end else if (we) begin
      if (off == OFF_CTRL) mode_q <= bus.data_write[CTRL_MODE_BIT];
      if (off == OFF_LED)  led_q  <= bus.data_write[NUM_LED-1:0];
    end
  end

  // W1C clear first, then OR in new presses so a simultaneous set survives.
  always_comb begin
    edge_d = edge_q;
    if (we && (off == OFF_EDGE)) edge_d = edge_q & ~bus.data_write[NUM_KEY-1:0];
    edge_d = edge_d | rise;
  end

  always_comb begin
    press_inc = '0;
    for (int i = 0; i < NUM_KEY; i++) press_inc = press_inc + PRESS_CNT_W'(rise[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) edge_q <= '0;
    else       edge_q <= edge_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      press_cnt_q <= '0;
    else if (|rise) press_cnt_q <= press_cnt_q + press_inc;
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL: rdata[CTRL_MODE_BIT]   = mode_q;
      OFF_LED:  rdata[NUM_LED-1:0]     = led_q;
      OFF_SW:   rdata[NUM_SW-1:0]      = sw_s2_q;
      OFF_KEY:  rdata[NUM_KEY-1:0]     = pressed;
      OFF_EDGE: rdata[NUM_KEY-1:0]     = edge_q;
      OFF_CNT:  rdata[PRESS_CNT_W-1:0] = press_cnt_q;
      default:  rdata = '0;
    endcase
  end

  assign bus.data_read = bus.hit ? rdata : 32'h0;

  // Zero-extend switches so LEDs beyond NUM_SW read 0 in legacy mode.
  always_comb begin
    sw_pad = '0;
    sw_pad[NUM_SW-1:0] = sw_s2_q;
    led = mode_q ? led_q : (sw_pad[NUM_LED-1:0] & {NUM_LED{~|pressed}});
  end

endmodule

// File: tb/tb_mmio_gpio.sv
module tb_mmio_gpio;

  localparam int KIND_RD  = 0;
  localparam int KIND_LED = 1;
  localparam int KIND_HIT = 2;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] sw;
  logic [2:0] key;
  logic [9:0] led;
  logic       chk_valid = 1'b0;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mmio_gpio_if bus_if ();

  mmio_gpio #(
    .NUM_SW         (10),
    .NUM_KEY        (3),
    .NUM_LED        (10),
    .BASE_ADDR      (32'h0000_0100),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave),
    .sw   (sw),
    .key  (key),
    .led  (led)
  );

  always #5 clk = ~clk;

  // Monitor: compares the DUT outputs against the oldest queued expectation
  // whenever the stimulus flags an observation cycle.
  always @(negedge clk) begin
    if (chk_valid) begin
      logic [31:0] act;
      exp_t        e;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: observation with no expected value queued");
      end else begin
        e = sb_q.pop_front();
        case (e.kind)
          KIND_RD:  act = bus_if.data_read;
          KIND_LED: act = 32'(led);
          default:  act = 32'(bus_if.hit);
        endcase
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input int kind, input logic [31:0] addr, input logic [31:0] exp,
                       input string name);
    bus_if.address       = addr;
    bus_if.enabler_write = 1'b0;
    sb_q.push_back('{kind, exp, name});
    chk_valid = 1'b1;
    step();
    chk_valid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus_if.address       = addr;
    bus_if.data_write    = data;
    bus_if.enabler_write = 1'b1;
    step();
    bus_if.enabler_write = 1'b0;
  endtask

  task automatic press(input int idx);
    key[idx] = 1'b0;
    repeat (8) step();
    key[idx] = 1'b1;
    repeat (8) step();
  endtask

  initial begin
    reset                = 1'b1;
    sw                   = 10'h3FF;
    key                  = 3'b111;
    bus_if.enabler_write = 1'b0;
    bus_if.address       = 32'h0;
    bus_if.data_write    = 32'h0;

    // Reset values
    repeat (3) step();
    check(KIND_LED, 32'h100, 32'h0, "led_in_reset");
    reset = 1'b0;
    step();
    step();
    check(KIND_LED, 32'h100, 32'h3FF, "led_after_sync");
    check(KIND_RD,  32'h100, 32'h0,   "ctrl_reset");
    check(KIND_RD,  32'h104, 32'h0,   "led_out_reset");
    check(KIND_RD,  32'h110, 32'h0,   "key_edge_reset");
    check(KIND_RD,  32'h114, 32'h0,   "press_cnt_reset");
    check(KIND_RD,  32'h108, 32'h3FF, "sw_in_reset");
    check(KIND_RD,  32'h10C, 32'h0,   "key_in_reset");
    check(KIND_HIT, 32'h100, 32'h1,   "hit_base");

    // Legacy mirror masked by a press; accepted on the 6th edge after the pin change
    sw = 10'h155;
    repeat (3) step();
    check(KIND_LED, 32'h100, 32'h155, "legacy_mirror");
    key = 3'b101;
    repeat (4) step();
    check(KIND_LED, 32'h100, 32'h155, "led_edge5");
    check(KIND_LED, 32'h100, 32'h155, "led_edge6_pending");
    check(KIND_LED, 32'h100, 32'h0,   "led_masked");
    check(KIND_RD,  32'h10C, 32'h2,   "key_in_pressed");
    check(KIND_RD,  32'h110, 32'h2,   "key_edge_set");
    check(KIND_RD,  32'h114, 32'h1,   "press_cnt_1");
    step();
    key = 3'b111;
    repeat (8) step();
    check(KIND_RD,  32'h10C, 32'h0,   "key_in_released");
    check(KIND_RD,  32'h110, 32'h2,   "release_no_edge");
    check(KIND_RD,  32'h114, 32'h1,   "release_no_count");
    check(KIND_LED, 32'h100, 32'h155, "legacy_unmasked");
    wr(32'h110, 32'h2);
    check(KIND_RD,  32'h110, 32'h0,   "w1c_clear");

    // Glitch shorter than the debounce window
    key = 3'b110;
    repeat (3) step();
    key = 3'b111;
    repeat (8) step();
    check(KIND_RD, 32'h10C, 32'h0, "glitch_key_in");
    check(KIND_RD, 32'h110, 32'h0, "glitch_key_edge");
    check(KIND_RD, 32'h114, 32'h1, "glitch_press_cnt");

    // Register mode and decode
    wr(32'h104, 32'h2A5);
    wr(32'h100, 32'h1);
    check(KIND_LED, 32'h100, 32'h2A5, "reg_mode_led");
    check(KIND_RD,  32'h104, 32'h2A5, "led_out_rd");
    check(KIND_RD,  32'h100, 32'h1,   "ctrl_rd");
    check(KIND_HIT, 32'h120, 32'h0,   "hit_outside");
    check(KIND_RD,  32'h120, 32'h0,   "read_outside");
    wr(32'h120, 32'h0);
    wr(32'h124, 32'h0);
    wr(32'h108, 32'hFFFF_FFFF);
    check(KIND_RD,  32'h100, 32'h1,   "ctrl_after_outside_wr");
    check(KIND_RD,  32'h104, 32'h2A5, "led_after_outside_wr");
    check(KIND_LED, 32'h100, 32'h2A5, "led_pin_after_outside_wr");
    check(KIND_RD,  32'h108, 32'h155, "sw_in_ro");
    check(KIND_HIT, 32'h11C, 32'h1,   "hit_top_word");
    check(KIND_RD,  32'h118, 32'h0,   "unmapped_18");
    check(KIND_RD,  32'h11C, 32'h0,   "unmapped_1c");

    // W1C colliding with a new press: set wins
    press(1);
    press(0);
    check(KIND_RD, 32'h110, 32'h3, "key_edge_011");
    check(KIND_RD, 32'h114, 32'h3, "press_cnt_3");
    key = 3'b110;
    repeat (5) step();
    wr(32'h110, 32'h1);
    check(KIND_RD, 32'h110, 32'h3, "w1c_set_wins");
    check(KIND_RD, 32'h114, 32'h4, "press_cnt_4");
    check(KIND_RD, 32'h10C, 32'h1, "key_in_key0");
    key = 3'b111;
    repeat (8) step();
    wr(32'h110, 32'h3);
    check(KIND_RD, 32'h110, 32'h0, "w1c_clear_both");

    // Counter wrap
    force dut.press_cnt_q = 16'hFFFF;
    step();
    release dut.press_cnt_q;
    check(KIND_RD, 32'h114, 32'hFFFF, "press_cnt_preload");
    press(2);
    check(KIND_RD, 32'h114, 32'h0, "press_cnt_wrap");
    check(KIND_RD, 32'h110, 32'h4, "key_edge_key2");

    repeat (2) step();
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
